// File: rtl/ntsc_time_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntsc_clock_pkg
// Description : Shared types and constants for the NTSC wall-clock time
//               keeper and display loader: loader states, BCD field layout,
//               digit limits, drunk-mode LFSR seed/taps, BCD advance helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ntsc_clock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RST_LO = 3'd1,
      ST_RST_HI = 3'd2,
      ST_BIT_LO = 3'd3,
      ST_BIT_HI = 3'd4
   } loader_state_e;

   // Bit positions of each digit inside the packed HH:MM:SS word
   localparam int unsigned SU_LSB = 0;
   localparam int unsigned ST_LSB = 4;
   localparam int unsigned MU_LSB = 8;
   localparam int unsigned MT_LSB = 12;
   localparam int unsigned HU_LSB = 16;
   localparam int unsigned HT_LSB = 20;

   // Digit limits
   localparam logic [3:0] UNITS_MAX       = 4'd9;
   localparam logic [3:0] TENS_MAX        = 4'd5;
   localparam logic [1:0] HOUR_T_MAX      = 2'd2;
   localparam logic [3:0] HOUR_U_MAX_LAST = 4'd3;

   // Right-shifting Galois LFSR, taps 16,14,13,11
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return l[0] ? ((l >> 1) ^ LFSR_TAPS) : (l >> 1);
   endfunction

   // One-second BCD increment; digits are not range-checked, so an
   // out-of-range digit simply counts up until it meets its limit.
   function automatic logic [23:0] bcd_advance(input logic [23:0] t);
      logic [3:0] su, st, mu, mt, hu;
      logic [1:0] ht;
      su = t[SU_LSB +: 4];
      st = t[ST_LSB +: 4];
      mu = t[MU_LSB +: 4];
      mt = t[MT_LSB +: 4];
      hu = t[HU_LSB +: 4];
      ht = t[HT_LSB +: 2];
      if (su != UNITS_MAX) su = su + 4'd1;
      else begin
         su = 4'd0;
         if (st != TENS_MAX) st = st + 4'd1;
         else begin
            st = 4'd0;
            if (mu != UNITS_MAX) mu = mu + 4'd1;
            else begin
               mu = 4'd0;
               if (mt != TENS_MAX) mt = mt + 4'd1;
               else begin
                  mt = 4'd0;
                  if (ht == HOUR_T_MAX && hu == HOUR_U_MAX_LAST) begin
                     ht = 2'd0;
                     hu = 4'd0;
                  end else if (hu != UNITS_MAX) begin
                     hu = hu + 4'd1;
                  end else begin
                     hu = 4'd0;
                     ht = ht + 2'd1;
                  end
               end
            end
         end
      end
      return {2'b00, ht, hu, mt, mu, st, su};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ntsc_time_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : ntsc_time_loader_if
// Description : Set-command handshake, time status and display serial port
//               of the NTSC time loader. slave = loader, master = its user.
// Revision    : 1.0 - initial release
// ============================================================================
interface ntsc_time_loader_if;
   logic        set_valid;
   logic        set_ready;
   logic [23:0] set_time;
   logic [23:0] time_bcd;
   logic        tick;
   logic        busy;
   logic        disp_wclk;
   logic        disp_din;
   logic        disp_rst;

   modport master (
      output set_valid, set_time,
      input  set_ready, time_bcd, tick, busy, disp_wclk, disp_din, disp_rst
   );

   modport slave (
      input  set_valid, set_time,
      output set_ready, time_bcd, tick, busy, disp_wclk, disp_din, disp_rst
   );
endinterface
`default_nettype wire

// File: rtl/ntsc_time_loader_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_time_counter
// Description : Per-second prescaler and packed-BCD HH:MM:SS counter with
//               time-set load. Optional macro NTSC_CLOCK_DRUNK_EN adds a
//               16-bit LFSR that jitters each second's length around
//               TICKS_PER_SEC while keeping the mean.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_time_counter
   import ntsc_clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 25_000_000,
   parameter int JITTER_BITS   = 20
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        set_load_i,
   input  wire logic [21:0] set_time_i,
   output logic      [23:0] time_bcd_o,
   output logic             tick_o
);
   // Wide enough for the longest jittered second as well as the fixed one
   localparam int PW = $clog2(TICKS_PER_SEC + (1 << JITTER_BITS)) + 1;

   logic [PW-1:0] presc_q, presc_d;
   logic [PW-1:0] period_w;
   logic [23:0]   time_q, time_d;
   logic          tick_q, tick_d;

`ifdef NTSC_CLOCK_DRUNK_EN
   localparam int BASE = TICKS_PER_SEC - (1 << (JITTER_BITS - 1));
   logic [15:0]   lfsr_q, lfsr_d;
   logic [PW-1:0] jitter_w;

   generate
      if (JITTER_BITS <= 16) begin : g_jit_narrow
         assign jitter_w = PW'(lfsr_q[JITTER_BITS-1:0]);
      end else begin : g_jit_wide
         assign jitter_w = PW'({lfsr_q, {(JITTER_BITS-16){1'b0}}});
      end
   endgenerate

   assign period_w = PW'(BASE) + jitter_w;

   // Draw a fresh period for every delivered second
   always_comb lfsr_d = tick_d ? lfsr_step(lfsr_q) : lfsr_q;

   // LFSR register, reseeded by reset
   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign period_w = PW'(TICKS_PER_SEC);
`endif

   // Next-state: a set overrides a coincident wrap and swallows its tick
   always_comb begin
      presc_d = presc_q + PW'(1);
      time_d  = time_q;
      tick_d  = 1'b0;
      if (set_load_i) begin
         time_d  = {2'b00, set_time_i};
         presc_d = '0;
      end else if (presc_q == period_w - PW'(1)) begin
         presc_d = '0;
         tick_d  = 1'b1;
         time_d  = bcd_advance(time_q);
      end
   end

   // Prescaler, time and tick registers
   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         time_q  <= '0;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         time_q  <= time_d;
         tick_q  <= tick_d;
      end
   end

   assign time_bcd_o = time_q;
   assign tick_o     = tick_q;
endmodule
`default_nettype wire

// File: rtl/ntsc_time_loader.sv
`default_nettype none
// ============================================================================
// Module      : ntsc_time_loader
// Description : NTSC wall-clock timekeeper and display loader. Keeps BCD
//               time via bcd_time_counter and, whenever the time changes,
//               sends a load-reset strobe followed by 24 bits MSB-first on
//               the display serial port. Option: NTSC_CLOCK_DRUNK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ntsc_time_loader
   import ntsc_clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 25_000_000,
   parameter int HALF_BIT      = 4,
   parameter int JITTER_BITS   = 20
) (
   input wire logic           clk,
   input wire logic           reset,
   ntsc_time_loader_if.slave  bus
);
   localparam int HW = (HALF_BIT > 1) ? $clog2(HALF_BIT) : 1;

   loader_state_e state_q, state_d;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [4:0]    idx_q, idx_d;
   logic [23:0]   shadow_q, shadow_d;
   logic          dirty_q, dirty_d;
   logic          wclk_q, wclk_d;
   logic          din_q, din_d;
   logic          drst_q, drst_d;

   logic [23:0]   time_w;
   logic          tick_w;
   logic          set_accept_w;
   logic          last_w;

   assign set_accept_w = bus.set_valid && (state_q == ST_IDLE);
   assign last_w       = (hcnt_q == HW'(HALF_BIT - 1));

   bcd_time_counter #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .JITTER_BITS   (JITTER_BITS)
   ) u_counter (
      .clk        (clk),
      .reset      (reset),
      .set_load_i (set_accept_w),
      .set_time_i (bus.set_time[21:0]),
      .time_bcd_o (time_w),
      .tick_o     (tick_w)
   );

   // Loader sequencing: each output change is decided one cycle ahead
   always_comb begin
      state_d  = state_q;
      hcnt_d   = last_w ? '0 : hcnt_q + 1'b1;
      idx_d    = idx_q;
      shadow_d = shadow_q;
      dirty_d  = dirty_q;
      wclk_d   = wclk_q;
      din_d    = din_q;
      drst_d   = drst_q;
      unique case (state_q)
         ST_IDLE: begin
            hcnt_d = '0;
            if (dirty_q) begin
               state_d  = ST_RST_LO;
               shadow_d = time_w;
               dirty_d  = 1'b0;
               idx_d    = 5'd23;
               drst_d   = 1'b1;
               wclk_d   = 1'b0;
               din_d    = 1'b0;
            end
         end
         ST_RST_LO: if (last_w) begin
            state_d = ST_RST_HI;
            wclk_d  = 1'b1;
         end
         ST_RST_HI: if (last_w) begin
            state_d = ST_BIT_LO;
            wclk_d  = 1'b0;
            drst_d  = 1'b0;
            din_d   = shadow_q[idx_q];
         end
         ST_BIT_LO: if (last_w) begin
            state_d = ST_BIT_HI;
            wclk_d  = 1'b1;
         end
         ST_BIT_HI: if (last_w) begin
            wclk_d = 1'b0;
            if (idx_q == 5'd0) begin
               state_d = ST_IDLE;
               din_d   = 1'b0;
            end else begin
               state_d = ST_BIT_LO;
               idx_d   = idx_q - 5'd1;
               din_d   = shadow_q[idx_q - 5'd1];
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A change during a frame is remembered and sent right after it
      if (tick_w || set_accept_w) dirty_d = 1'b1;
   end

   // Loader state and registered display outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         hcnt_q   <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         dirty_q  <= 1'b1;
         wclk_q   <= 1'b0;
         din_q    <= 1'b0;
         drst_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         hcnt_q   <= hcnt_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         dirty_q  <= dirty_d;
         wclk_q   <= wclk_d;
         din_q    <= din_d;
         drst_q   <= drst_d;
      end
   end

   assign bus.set_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.time_bcd  = time_w;
   assign bus.tick      = tick_w;
   assign bus.disp_wclk = wclk_q;
   assign bus.disp_din  = din_q;
   assign bus.disp_rst  = drst_q;
endmodule
`default_nettype wire

// File: tb/tb_ntsc_time_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ntsc_time_loader
// Description : Self-checking bench for ntsc_time_loader. A seconds-of-day
//               reference model predicts time_bcd/tick each cycle and the
//               frame content at every load reset; a separate monitor
//               decodes the serial port and checks frames against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ntsc_time_loader;
   localparam int TPS = 10;
   localparam int HB  = 1;
   localparam int JB  = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   ntsc_time_loader_if bus();

   ntsc_time_loader #(
      .TICKS_PER_SEC (TPS),
      .HALF_BIT      (HB),
      .JITTER_BITS   (JB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model (seconds of day) ----------------
   function automatic int bcd2sec(input logic [23:0] b);
      return (int'(b[21:20]) * 10 + int'(b[19:16])) * 3600
           + (int'(b[15:12]) * 10 + int'(b[11:8])) * 60
           +  int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

   function automatic logic [23:0] sec2bcd(input int s);
      int h, m, x;
      h = s / 3600;
      m = (s / 60) % 60;
      x = s % 60;
      return {2'b00, 2'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
   endfunction

   int          m_secs = 0;
   int          m_pc   = 0;
   logic        m_tick = 1'b0;
   logic [15:0] m_lfsr = 16'hACE1;
   logic [23:0] m_last = '0;
   logic        m_prev_drst = 1'b0;
   logic [23:0] exp_q[$];

   function automatic int cur_period();
`ifdef NTSC_CLOCK_DRUNK_EN
      return TPS - (1 << (JB - 1)) + int'(m_lfsr & 16'((1 << JB) - 1));
`else
      return TPS;
`endif
   endfunction

   // Model: compare current cycle, predict frame snapshots, advance one cycle
   always @(negedge clk) begin
      if (reset) exp_q.delete();
      else if (bus.disp_rst && !m_prev_drst) exp_q.push_back(m_last);
      m_prev_drst = bus.disp_rst;
      check("time_bcd", {8'h0, bus.time_bcd}, {8'h0, sec2bcd(m_secs)});
      check("tick", {31'h0, bus.tick}, {31'h0, m_tick});
      m_last = sec2bcd(m_secs);
      m_tick = 1'b0;
      if (reset) begin
         m_secs = 0;
         m_pc   = 0;
         m_lfsr = 16'hACE1;
      end else if (bus.set_valid && bus.set_ready) begin
         m_secs = bcd2sec(bus.set_time);
         m_pc   = 0;
      end else if (m_pc == cur_period() - 1) begin
         m_pc   = 0;
         m_secs = (m_secs + 1) % 86400;
         m_tick = 1'b1;
         m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      end else begin
         m_pc++;
      end
   end

   // ---------------- serial-port monitor ----------------
   int          mon_bits  = 0;
   int          mon_rsts  = 0;
   logic [23:0] mon_sh    = '0;
   logic        in_frame  = 1'b0;
   logic        p_wclk = 1'b0, p_din = 1'b0, p_rst = 1'b0;

   always @(negedge clk) begin
      if (reset) begin
         mon_bits = 0;
         mon_rsts = 0;
         in_frame = 1'b0;
      end else begin
         if (p_wclk && bus.disp_wclk)
            check("din_rst_stable_wclk_high", {30'h0, bus.disp_din, bus.disp_rst}, {30'h0, p_din, p_rst});
         if (bus.disp_rst && !p_rst) begin
            check("frame_not_aborted", {31'h0, in_frame}, 32'h0);
            in_frame = 1'b1;
            mon_bits = 0;
            mon_rsts = 0;
         end
         if (in_frame) check("set_ready_low_in_frame", {31'h0, bus.set_ready}, 32'h0);
         if (bus.disp_wclk && !p_wclk) begin
            if (bus.disp_rst) mon_rsts++;
            else begin
               mon_bits++;
               mon_sh = {mon_sh[22:0], bus.disp_din};
               if (mon_bits == 24) begin
                  check("rst_pulses_per_frame", mon_rsts, 1);
                  if (exp_q.size() == 0) check("frame_expected", 32'h0, 32'h1);
                  else check("frame_data", {8'h0, mon_sh}, {8'h0, exp_q.pop_front()});
                  in_frame = 1'b0;
                  mon_bits = 0;
               end
            end
         end
      end
      p_wclk = bus.disp_wclk;
      p_din  = bus.disp_din;
      p_rst  = bus.disp_rst;
   end

   // ---------------- stimulus ----------------
   task automatic do_set(input logic [23:0] t);
      int ok;
      ok = 0;
      bus.set_valid = 1'b1;
      bus.set_time  = t;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.set_ready) begin ok = 1; break; end
      end
      @(posedge clk); #1;
      bus.set_valid = 1'b0;
      if (ok == 0) check("set_accept_timeout", 32'h0, 32'h1);
   endtask

   task automatic wait_tick(output int n);
      n = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.tick) begin n = i; break; end
      end
      if (n < 0) check("tick_timeout", 32'h0, 32'h1);
   endtask

   logic h_rst[1:52];
   logic h_busy[1:52];

   initial begin
      int n;
      int found;
      logic [23:0] t;
      bus.set_valid = 1'b0;
      bus.set_time  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", {31'h0, bus.busy}, 32'h0);
      check("rst_wclk", {31'h0, bus.disp_wclk}, 32'h0);
      check("rst_din", {31'h0, bus.disp_din}, 32'h0);
      check("rst_disp_rst", {31'h0, bus.disp_rst}, 32'h0);
      check("rst_set_ready", {31'h0, bus.set_ready}, 32'h1);
      reset = 1'b0;

      // First frame right after reset: load reset for 2 cycles, 50 busy cycles
      for (int i = 1; i <= 52; i++) begin
         @(posedge clk); #1;
         h_rst[i]  = bus.disp_rst;
         h_busy[i] = bus.busy;
      end
      check("first_rst_e1", {31'h0, h_rst[1]}, 32'h1);
      check("first_rst_e2", {31'h0, h_rst[2]}, 32'h1);
      check("first_rst_e3", {31'h0, h_rst[3]}, 32'h0);
      check("first_busy_e50", {31'h0, h_busy[50]}, 32'h1);
      check("first_busy_e51", {31'h0, h_busy[51]}, 32'h0);

      // Midnight rollover and carries
      do_set(24'h235959); wait_tick(n);
      check("rollover", {8'h0, bus.time_bcd}, 32'h000000);
      do_set(24'h095959); wait_tick(n);
      check("hour_carry", {8'h0, bus.time_bcd}, 32'h100000);
      do_set(24'h000009); wait_tick(n);
      check("sec_carry", {8'h0, bus.time_bcd}, 32'h000010);

      // set_valid held during a frame waits for IDLE; prescaler restarts
      wait_tick(n);
      repeat (3) @(posedge clk);
      #1;
      check("held_not_ready", {31'h0, bus.set_ready}, 32'h0);
      do_set(24'h123456);
      wait_tick(n);
`ifndef NTSC_CLOCK_DRUNK_EN
      check("tick_after_set", n, TPS);
`endif
      check("after_set_time", {8'h0, bus.time_bcd}, 32'h123457);

      // Set coinciding with a prescaler wrap: set wins, no tick
      found = 0;
      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         if (bus.set_ready && m_pc == cur_period() - 1) begin
            bus.set_valid = 1'b1;
            bus.set_time  = 24'h074200;
            @(posedge clk); #1;
            bus.set_valid = 1'b0;
            check("coincide_time", {8'h0, bus.time_bcd}, 32'h074200);
            check("coincide_no_tick", {31'h0, bus.tick}, 32'h0);
            found = 1;
            break;
         end
      end
      if (found == 0) check("coincide_found", 32'h0, 32'h1);

      // Reset in the middle of bit 12
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (bus.disp_rst) begin found = 1; break; end
      end
      if (found == 0) check("frame_start_timeout", 32'h0, 32'h1);
      repeat (24) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      check("midreset_time", {8'h0, bus.time_bcd}, 32'h0);
      check("midreset_busy", {31'h0, bus.busy}, 32'h0);
      check("midreset_wclk", {31'h0, bus.disp_wclk}, 32'h0);
      check("midreset_din", {31'h0, bus.disp_din}, 32'h0);
      check("midreset_rst", {31'h0, bus.disp_rst}, 32'h0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("restart_rst", {31'h0, bus.disp_rst}, 32'h1);

      // Randomized sets at random moments
      for (int k = 0; k < 15; k++) begin
         repeat ($urandom_range(80)) @(posedge clk);
         #1;
         t = sec2bcd(int'($urandom_range(86399)));
         do_set(t);
      end

      repeat (150) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
